// File: rtl/am_ramp_modulator.sv
// Double-sideband AM modulator with soft-ramped depth; 3-cycle latency, no backpressure (one sample per clk).
// Define AM_OVERMOD_EN for a doubled envelope gain (depth 255 ~ 200 %, phase reversal, saturation active).
module am_ramp_modulator #(
    parameter int PIPE_LAT = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] cos_s,
    input  logic [7:0] cos_c,
    input  logic [7:0] depth,
    input  logic [7:0] ramp_step,
    output logic [7:0] am_out,
    output logic [7:0] dac_out,
    output logic       out_valid,
    output logic [1:0] state,
    output logic [7:0] depth_cur
);

`ifdef AM_OVERMOD_EN
    localparam int ENV_SHIFT = 6;
`else
    localparam int ENV_SHIFT = 7;
`endif

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        RUN       = 2'd2,
        RAMP_DOWN = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  depth_q, depth_d;
    logic [8:0]  up_sum;

    assign up_sum    = {1'b0, depth_q} + {1'b0, ramp_step};
    assign state     = state_q;
    assign depth_cur = depth_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            depth_q <= '0;
        end else begin
            state_q <= state_d;
            depth_q <= depth_d;
        end
    end

    // en is tested before ramp completion so a toggle always wins
    always_comb begin
        state_d = state_q;
        depth_d = depth_q;
        case (state_q)
            IDLE: begin
                depth_d = '0;
                if (en) state_d = RAMP_UP;
            end
            RAMP_UP: begin
                if (!en) begin
                    state_d = RAMP_DOWN;
                end else if (ramp_step == 8'd0 || up_sum >= {1'b0, depth}) begin
                    depth_d = depth;
                    state_d = RUN;
                end else begin
                    depth_d = up_sum[7:0];
                end
            end
            RUN: begin
                depth_d = depth;
                if (!en) state_d = RAMP_DOWN;
            end
            RAMP_DOWN: begin
                if (en) begin
                    state_d = RAMP_UP;
                end else if (ramp_step == 8'd0 || depth_q <= ramp_step) begin
                    depth_d = '0;
                    state_d = IDLE;
                end else begin
                    depth_d = depth_q - ramp_step;
                end
            end
            default: begin
                state_d = IDLE;
                depth_d = '0;
            end
        endcase
    end

    // S1: centred modulator times applied depth
    logic signed [8:0]  mod_s;
    logic signed [16:0] mod_ext, depth_ext, prod1;
    logic signed [16:0] p1;
    logic signed [7:0]  c1;

    assign mod_s     = $signed({1'b0, cos_s}) - 9'sd128;
    assign mod_ext   = {{8{mod_s[8]}}, mod_s};
    assign depth_ext = {9'd0, depth_q};
    assign prod1     = mod_ext * depth_ext;

    // S2: envelope around unity (256) times carrier
    logic signed [16:0] env;
    logic signed [18:0] env_ext, c1_ext, prod2;
    logic signed [18:0] p2;

    assign env     = 17'sd256 + (p1 >>> ENV_SHIFT);
    assign env_ext = {{2{env[16]}}, env};
    assign c1_ext  = {{11{c1[7]}}, c1};
    assign prod2   = c1_ext * env_ext;

    // S3: rescale and clamp to the 8-bit signed range
    logic signed [18:0] scaled;
    logic [7:0]         sat;
    logic [7:0]         am_q;

    assign scaled = p2 >>> 9;

    always_comb begin
        sat = scaled[7:0];
        if (scaled > 19'sd127)
            sat = 8'h7F;
        else if (scaled < -19'sd128)
            sat = 8'h80;
    end

    logic [PIPE_LAT-1:0] vld_sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1     <= '0;
            c1     <= '0;
            p2     <= '0;
            am_q   <= '0;
            vld_sr <= '0;
        end else begin
            p1     <= prod1;
            c1     <= $signed(cos_c);
            p2     <= prod2;
            am_q   <= sat;
            vld_sr <= {vld_sr[PIPE_LAT-2:0], 1'b1};
        end
    end

    assign am_out    = am_q;
    assign dac_out   = {~am_q[7], am_q[6:0]};
    assign out_valid = vld_sr[PIPE_LAT-1];

endmodule

// File: tb/tb_am_ramp_modulator.sv
// Scoreboarded bench for am_ramp_modulator: arithmetic reference model, directed ramps, random traffic.
module tb_am_ramp_modulator;

`ifdef AM_OVERMOD_EN
    localparam int ENV_DIV = 64;
`else
    localparam int ENV_DIV = 128;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] cos_s, cos_c, depth, ramp_step;
    logic [7:0] am_out, dac_out, depth_cur;
    logic       out_valid;
    logic [1:0] state;

    am_ramp_modulator #(.PIPE_LAT(3)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .cos_s(cos_s), .cos_c(cos_c),
        .depth(depth), .ramp_step(ramp_step), .am_out(am_out), .dac_out(dac_out),
        .out_valid(out_valid), .state(state), .depth_cur(depth_cur)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int exp_q[$];
    int m_st = 0;
    int m_d = 0;
    int edges = 0;

    task automatic chk(string nm, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int fdiv(int a, int b);
        int q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    // Envelope/carrier arithmetic straight from the real-valued definition
    function automatic int model_am(int s, int c, int d);
        int env, a;
        env = 256 + fdiv((s - 128) * d, ENV_DIV);
        a = fdiv(c * env, 512);
        if (a > 127) a = 127;
        if (a < -128) a = -128;
        return a;
    endfunction

    task automatic tick();
        int n_st, n_d;
        exp_q.push_back(model_am(int'(cos_s), int'($signed(cos_c)), m_d));
        n_st = m_st;
        n_d  = m_d;
        case (m_st)
            0: begin n_d = 0; if (en) n_st = 1; end
            1: if (!en) n_st = 3;
               else if (ramp_step == 0 || m_d + int'(ramp_step) >= int'(depth)) begin
                   n_d = depth; n_st = 2;
               end else n_d = m_d + int'(ramp_step);
            2: begin n_d = depth; if (!en) n_st = 3; end
            default: if (en) n_st = 1;
               else if (ramp_step == 0 || m_d <= int'(ramp_step)) begin
                   n_d = 0; n_st = 0;
               end else n_d = m_d - int'(ramp_step);
        endcase
        @(posedge clk);
        m_st = n_st;
        m_d  = n_d;
        edges++;
        @(negedge clk);
    endtask

    task automatic expect_sd(string nm, int st, int d);
        chk({nm, " state"}, int'(state), st);
        chk({nm, " depth_cur"}, int'(depth_cur), d);
    endtask

    task automatic go_idle();
        en = 1'b0;
        ramp_step = 8'd0;
        for (int i = 0; i < 4 && m_st != 0; i++) tick();
        chk("go_idle state", int'(state), 0);
    endtask

    // Monitor: pipeline outputs against the scoreboard, FSM against the model
    initial begin
        int e;
        forever begin
            @(posedge clk);
            #2;
            if (rst_n) begin
                chk("mon state", int'(state), m_st);
                chk("mon depth_cur", int'(depth_cur), m_d);
                chk("mon out_valid", int'(out_valid), (edges >= 3) ? 1 : 0);
                if (edges >= 3) begin
                    if (exp_q.size() == 0) begin
                        chk("mon queue underflow", 0, 1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("mon am_out", int'($signed(am_out)), e);
                        chk("mon dac_out", int'(dac_out), e + 128);
                    end
                end
            end
        end
    end

    int seq_d[5], seq_s[5];
    int ab_d[9], ab_s[9];
    int dir_s[3], dir_c[3], dir_a[3];

    initial begin
        rst_n = 1'b0; en = 1'b0; cos_s = 8'd200; cos_c = 8'd100;
        depth = 8'd0; ramp_step = 8'd0;
        #1;
        expect_sd("reset", 0, 0);
        chk("reset am_out", int'(am_out), 0);
        chk("reset dac_out", int'(dac_out), 8'h80);
        chk("reset out_valid", int'(out_valid), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // idle carrier pass-through at half amplitude
        tick(); tick();
        chk("fill out_valid low", int'(out_valid), 0);
        tick();
        chk("idle out_valid", int'(out_valid), 1);
        chk("idle am_out", int'($signed(am_out)), 50);
        chk("idle dac_out", int'(dac_out), 8'hB2);
        chk("idle state", int'(state), 0);

        // full depth, directed corner samples
`ifdef AM_OVERMOD_EN
        dir_s = '{255, 0, 128};  dir_c = '{127, 127, 100};  dir_a = '{127, -64, 50};
`else
        dir_s = '{255, 0, 255};  dir_c = '{100, 100, 128};  dir_a = '{99, 0, -128};
`endif
        en = 1'b1; depth = 8'd255; ramp_step = 8'd0;
        tick(); tick();
        expect_sd("run full", 2, 255);
        for (int i = 0; i < 3; i++) begin
            cos_s = 8'(dir_s[i]);
            cos_c = 8'(dir_c[i]);
            tick(); tick(); tick();
            chk("full depth am_out", int'($signed(am_out)), dir_a[i]);
        end

        // ramp up then down at step 50
        go_idle();
        depth = 8'd200; ramp_step = 8'd50; en = 1'b1;
        seq_d = '{0, 50, 100, 150, 200};  seq_s = '{1, 1, 1, 1, 2};
        for (int i = 0; i < 5; i++) begin tick(); expect_sd("ramp up", seq_s[i], seq_d[i]); end
        en = 1'b0;
        seq_d = '{200, 150, 100, 50, 0};  seq_s = '{3, 3, 3, 3, 0};
        for (int i = 0; i < 5; i++) begin tick(); expect_sd("ramp down", seq_s[i], seq_d[i]); end

        // abort a ramp-up and resume it
        ab_d = '{0, 50, 100, 100, 50, 50, 100, 150, 200};
        ab_s = '{1, 1, 1, 3, 3, 1, 1, 1, 2};
        for (int i = 0; i < 9; i++) begin
            en = (i == 3 || i == 4) ? 1'b0 : 1'b1;
            tick();
            expect_sd("abort", ab_s[i], ab_d[i]);
        end

        // instantaneous step
        go_idle();
        depth = 8'd180; ramp_step = 8'd0; en = 1'b1;
        tick(); expect_sd("step0 up", 1, 0);
        tick(); expect_sd("step0 run", 2, 180);
        en = 1'b0;
        tick(); expect_sd("step0 down", 3, 180);
        tick(); expect_sd("step0 idle", 0, 0);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) en = ~en;
            if ($urandom_range(0, 31) == 0) depth = 8'($urandom);
            if ($urandom_range(0, 31) == 0)
                ramp_step = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 80));
            cos_s = 8'($urandom);
            cos_c = 8'($urandom);
            tick();
        end

        // reset in the middle of a ramp-up
        go_idle();
        depth = 8'd255; ramp_step = 8'd1; en = 1'b1;
        tick(); tick(); tick();
        expect_sd("pre-reset", 1, 2);
        rst_n = 1'b0;
        #1;
        expect_sd("mid reset", 0, 0);
        chk("mid reset am_out", int'(am_out), 0);
        chk("mid reset dac_out", int'(dac_out), 8'h80);
        chk("mid reset out_valid", int'(out_valid), 0);
        exp_q.delete();
        m_st = 0; m_d = 0; edges = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            cos_s = 8'($urandom);
            cos_c = 8'($urandom);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
